// File: rtl/i2s_mic_sequencer.sv
// I2S MEMS microphone master sequencer.
// Generates bclk/lrclk/sel and steps the mic through warm-up, run and a
// stop that always finishes on a frame boundary. The selected channel is
// deserialised MSB-first into a signed sample with a one-cycle valid strobe.
// Everything runs in the clk_gen_fast domain.
//
// Data handshake: sample_valid is a one-cycle strobe with no ready; the
// consumer must take sample_data in the cycle sample_valid is high.
// sample_data then holds until the next capture.
//
// Assumes DIV even and >= 2, SAMPLE_BITS in 2..BITS-1.
module i2s_mic_sequencer #(
  parameter int DIV           = 4,
  parameter int BITS          = 32,
  parameter int SAMPLE_BITS   = 24,
  parameter int WARMUP_FRAMES = 4096
) (
  input  logic                   clk_gen_fast,
  input  logic                   arstn,
  input  logic                   enable,
  input  logic                   sel_cfg,
  input  logic                   data,
  output logic                   bclk,
  output logic                   lrclk,
  output logic                   sel,
  output logic [SAMPLE_BITS-1:0] sample_data,
  output logic                   sample_valid,
  output logic [1:0]             state
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WARMUP = 2'd1,
    ST_RUN    = 2'd2,
    ST_STOP   = 2'd3
  } state_t;

  localparam int PH_W   = (DIV > 2) ? $clog2(DIV) : 1;
  localparam int SLOT_W = $clog2(2 * BITS);
  localparam int FR_W   = (WARMUP_FRAMES > 1) ? $clog2(WARMUP_FRAMES) : 1;

  localparam logic [PH_W-1:0]   PH_LAST   = PH_W'(DIV - 1);
  localparam logic [PH_W-1:0]   PH_HALF   = PH_W'(DIV / 2);
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(2 * BITS - 1);
  localparam logic [SLOT_W-1:0] SLOT_HALF = SLOT_W'(BITS);
  localparam logic [SLOT_W-1:0] H_FIRST   = SLOT_W'(1);
  localparam logic [SLOT_W-1:0] H_LAST    = SLOT_W'(SAMPLE_BITS);
  localparam logic [FR_W-1:0]   FR_LAST   = FR_W'(WARMUP_FRAMES - 1);

  state_t                 state_q;
  logic [PH_W-1:0]        ph;
  logic [SLOT_W-1:0]      slot;
  logic [FR_W-1:0]        frame_cnt;
  logic [SAMPLE_BITS-1:0] shreg;
  logic                   sel_q;

  logic                   ph_wrap;
  logic                   frame_end;
  logic                   right_half;
  logic [SLOT_W-1:0]      half_idx;
  logic                   capture;
  logic [PH_W-1:0]        ph_nxt;
  logic [SLOT_W-1:0]      slot_nxt;
  logic [SAMPLE_BITS-1:0] word_nxt;

  assign state = state_q;
  assign sel   = sel_q;

  // Slot/phase decode and next counter values; bclk and lrclk are
  // registered from the next values so they line up with ph and slot.
  always_comb begin
    ph_wrap    = (ph == PH_LAST);
    frame_end  = ph_wrap && (slot == SLOT_LAST);
    right_half = (slot >= SLOT_HALF);
    half_idx   = right_half ? (slot - SLOT_HALF) : slot;
    capture    = (state_q != ST_IDLE) && ph_wrap && (right_half == sel_q) &&
                 (half_idx >= H_FIRST) && (half_idx <= H_LAST);
    word_nxt   = {shreg[SAMPLE_BITS-2:0], data};
    ph_nxt     = '0;
    slot_nxt   = '0;
    if (state_q != ST_IDLE) begin
      ph_nxt   = ph_wrap ? '0 : ph + PH_W'(1);
      slot_nxt = slot;
      if (ph_wrap) begin
        slot_nxt = (slot == SLOT_LAST) ? '0 : slot + SLOT_W'(1);
      end
    end
  end

  // Sequencer FSM, clock generation and bit capture.
  always_ff @(posedge clk_gen_fast or negedge arstn) begin
    if (!arstn) begin
      state_q      <= ST_IDLE;
      ph           <= '0;
      slot         <= '0;
      frame_cnt    <= '0;
      shreg        <= '0;
      sel_q        <= 1'b0;
      bclk         <= 1'b0;
      lrclk        <= 1'b0;
      sample_data  <= '0;
      sample_valid <= 1'b0;
    end else begin
      sample_valid <= 1'b0;
      ph           <= ph_nxt;
      slot         <= slot_nxt;
      bclk         <= (ph_nxt >= PH_HALF);
      lrclk        <= (slot_nxt >= SLOT_HALF);

      if (capture) begin
        shreg <= word_nxt;
        if ((half_idx == H_LAST) && (state_q == ST_RUN)) begin
          sample_data  <= word_nxt;
          sample_valid <= 1'b1;
        end
      end

      case (state_q)
        ST_IDLE: begin
          frame_cnt <= '0;
          if (enable) begin
            sel_q   <= sel_cfg;
            state_q <= ST_WARMUP;
          end
        end
        ST_WARMUP: begin
          // Dropping enable beats the last warm-up boundary.
          if (!enable) begin
            state_q <= ST_STOP;
          end else if (frame_end) begin
            if (frame_cnt == FR_LAST) begin
              state_q <= ST_RUN;
            end else begin
              frame_cnt <= frame_cnt + FR_W'(1);
            end
          end
        end
        ST_RUN: begin
          if (!enable) begin
            state_q <= ST_STOP;
          end
        end
        ST_STOP: begin
          if (frame_end) begin
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_i2s_mic_sequencer.sv
// Directed bench for i2s_mic_sequencer with WARMUP_FRAMES=2 and defaults
// otherwise. A behavioural mic follows bclk/lrclk and shifts out per-channel
// words MSB-first starting one slot after each lrclk change; bits outside
// the sample window are random.
module tb_i2s_mic_sequencer;

  localparam int DIV  = 4;
  localparam int SB   = 24;
  localparam int WARM = 512;   // 2 frames * 256 cycles

  logic          clk_gen_fast;
  logic          arstn;
  logic          enable;
  logic          sel_cfg;
  logic          data;
  logic          bclk;
  logic          lrclk;
  logic          sel;
  logic [SB-1:0] sample_data;
  logic          sample_valid;
  logic [1:0]    state;

  int checks = 0;
  int errors = 0;

  logic [SB-1:0] left_word  = 24'h0;
  logic [SB-1:0] right_word = 24'h0;

  i2s_mic_sequencer #(
    .DIV(4), .BITS(32), .SAMPLE_BITS(24), .WARMUP_FRAMES(2)
  ) dut (
    .clk_gen_fast(clk_gen_fast),
    .arstn(arstn),
    .enable(enable),
    .sel_cfg(sel_cfg),
    .data(data),
    .bclk(bclk),
    .lrclk(lrclk),
    .sel(sel),
    .sample_data(sample_data),
    .sample_valid(sample_valid),
    .state(state)
  );

  // Clock
  initial clk_gen_fast = 1'b0;
  always #5 clk_gen_fast = ~clk_gen_fast;

  // Mic model: on each bclk rise pick the bit for the current slot.
  logic          prev_bclk = 1'b0;
  logic          lr_prev   = 1'b0;
  int            gap       = 1000;
  int            h_m       = 0;
  logic [SB-1:0] w_m;
  initial data = 1'b0;
  always @(negedge clk_gen_fast) begin
    if (bclk && !prev_bclk) begin
      if (gap > DIV || lrclk != lr_prev) begin
        h_m     = 0;
        lr_prev = lrclk;
      end else begin
        h_m = h_m + 1;
      end
      gap = 0;
      w_m = lrclk ? right_word : left_word;
      if (h_m >= 1 && h_m <= SB) data = w_m[SB - h_m];
      else data = 1'($urandom_range(0, 1));
    end else if (gap < 1000) begin
      gap = gap + 1;
    end
    prev_bclk = bclk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_state"}, 32'(state), 32'd0);
    chk({tag, "_bclk"},  32'(bclk), 32'd0);
    chk({tag, "_lrclk"}, 32'(lrclk), 32'd0);
    chk({tag, "_sel"},   32'(sel), 32'd0);
    chk({tag, "_data"},  32'(sample_data), 32'd0);
    chk({tag, "_valid"}, 32'(sample_valid), 32'd0);
  endtask

  // Expectations for cycle i after the IDLE->WARMUP transition.
  task automatic check_cycle(input int i, input int valid_off,
                             input logic [SB-1:0] w, input logic s);
    logic exp_valid;
    exp_valid = (i >= WARM) && ((i % 256) == valid_off);
    chk($sformatf("state@%0d", i), 32'(state), (i < WARM) ? 32'd1 : 32'd2);
    chk($sformatf("bclk@%0d", i),  32'(bclk),  32'((i % DIV) >= DIV / 2));
    chk($sformatf("lrclk@%0d", i), 32'(lrclk), 32'((i % 256) >= 128));
    chk($sformatf("sel@%0d", i),   32'(sel),   32'(s));
    chk($sformatf("valid@%0d", i), 32'(sample_valid), 32'(exp_valid));
    if (i >= WARM + valid_off)
      chk($sformatf("sdata@%0d", i), 32'(sample_data), 32'(w));
  endtask

  initial begin
    arstn   = 1'b0;
    enable  = 1'b1;
    sel_cfg = 1'b0;

    // Reset held with enable high: everything static at zero.
    for (int k = 0; k < 5; k++) begin
      @(negedge clk_gen_fast);
      chk_reset($sformatf("rst%0d", k));
    end
    enable = 1'b0;
    arstn  = 1'b1;
    repeat (2) @(negedge clk_gen_fast);
    chk("idle_no_enable", 32'(state), 32'd0);
    chk("idle_bclk", 32'(bclk), 32'd0);

    // Left capture through warm-up and two run frames.
    left_word  = 24'hA5C3F1;
    right_word = 24'h3C3C3C;
    sel_cfg    = 1'b0;
    enable     = 1'b1;
    for (int i = 0; i < 1065; i++) begin
      @(negedge clk_gen_fast);
      check_cycle(i, 100, 24'hA5C3F1, 1'b0);
    end

    // Stop requested at slot 10 of the third run frame (cycle 1064).
    enable = 1'b0;
    for (int i = 1065; i < 1280; i++) begin
      @(negedge clk_gen_fast);
      chk($sformatf("stop_state@%0d", i), 32'(state), 32'd3);
      chk($sformatf("stop_bclk@%0d", i),  32'(bclk), 32'((i % DIV) >= DIV / 2));
      chk($sformatf("stop_lrclk@%0d", i), 32'(lrclk), 32'((i % 256) >= 128));
      chk($sformatf("stop_valid@%0d", i), 32'(sample_valid), 32'd0);
    end
    for (int i = 1280; i < 1320; i++) begin
      @(negedge clk_gen_fast);
      chk($sformatf("idle_state@%0d", i), 32'(state), 32'd0);
      chk($sformatf("idle_bclk@%0d", i),  32'(bclk), 32'd0);
      chk($sformatf("idle_lrclk@%0d", i), 32'(lrclk), 32'd0);
      chk($sformatf("idle_valid@%0d", i), 32'(sample_valid), 32'd0);
    end
    chk("hold_after_stop", 32'(sample_data), 32'h00A5C3F1);

    // Right capture: left words must never reach the output.
    left_word  = 24'h111111;
    right_word = 24'h800001;
    sel_cfg    = 1'b1;
    enable     = 1'b1;
    for (int i = 0; i < 1105; i++) begin
      @(negedge clk_gen_fast);
      check_cycle(i, 228, 24'h800001, 1'b1);
    end

    // Reset pulse at slot 20 of a run frame (cycle 1104).
    arstn = 1'b0;
    #1;
    chk_reset("midrun");
    for (int k = 0; k < 3; k++) begin
      @(negedge clk_gen_fast);
      chk_reset($sformatf("midrun%0d", k));
    end
    arstn = 1'b1;

    // Full warm-up repeats before the first sample.
    for (int i = 0; i < 770; i++) begin
      @(negedge clk_gen_fast);
      check_cycle(i, 228, 24'h800001, 1'b1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/i2s_mic_sequencer.md
Name: i2s_mic_sequencer

Overview:
- Master-side timing controller for the I2S MEMS microphone.
- Generates bclk, lrclk and sel, and sequences the mic through power-up warm-up, run and clean stop at a frame boundary.
- Deserialises the selected channel into signed samples with a one-cycle valid strobe.
- Sits entirely in the clk_gen_fast domain, ahead of the CDC and DC-block/decimation path.

Parameters:
- DIV, 4: clk_gen_fast cycles per bclk period; even, at least 2.
- BITS, 32: bclk slots per channel half-frame (frame = 2*BITS slots).
- SAMPLE_BITS, 24: MSBs captured per sample; at most BITS-1.
- WARMUP_FRAMES, 4096: complete frames discarded after clocks start (64 ms at 64 kHz).

Ports:
- clk_gen_fast, in, 1: fast clock (16.384 MHz).
- arstn, in, 1: asynchronous reset, active-low.
- enable, in, 1: level request to run the mic.
- sel_cfg, in, 1: mic channel; 0 = left (lrclk low), 1 = right.
- data, in, 1: mic serial data.
- bclk, out, 1: mic bit clock.
- lrclk, out, 1: word select.
- sel, out, 1: mic L/R select pin.
- sample_data, out, SAMPLE_BITS: signed captured sample, MSB first.
- sample_valid, out, 1: one-cycle pulse, sample_data valid.
- state, out, 2: IDLE=0, WARMUP=1, RUN=2, STOP=3.

Behaviour:
- Reset (arstn low, asynchronous, any time): state=IDLE, bclk=0, lrclk=0, sel=0, sample_data=0, sample_valid=0. Phase, slot, frame counters and shift register are cleared. A reset mid-run discards the partial sample and a later enable repeats the full warm-up.
- Phase counter ph, 0..DIV-1:
  - Runs only in WARMUP/RUN/STOP.
  - bclk is registered: 0 for ph<DIV/2, 1 for ph>=DIV/2.
  - Bit sample point is the cycle with ph==DIV-1; data is registered on that clk_gen_fast edge.
- Slot counter, 0..2*BITS-1:
  - Advances on ph wrap DIV-1 -> 0 and wraps 2*BITS-1 -> 0. That wrap is the frame boundary.
  - lrclk = (slot >= BITS), registered, so it changes together with a bclk falling edge.
- Half-slot h = slot mod BITS. I2S one-bit delay applies: MSB is at h=1, bit SAMPLE_BITS-1-k at h=1+k, for h in 1..SAMPLE_BITS. Bits outside that range are ignored.
- Capture occurs only in the half matching the latched sel (lrclk==sel).
- Output on the sample point of h==SAMPLE_BITS in RUN: on the next cycle sample_data = assembled word and sample_valid=1 for exactly one cycle.
  - sample_data holds until the next capture.
  - One sample per frame, every 2*BITS*DIV cycles (256 at defaults).
  - No backpressure.
- FSM:
  - IDLE: bclk=0, lrclk=0, counters held at 0. If enable=1, latch sel<=sel_cfg and go to WARMUP next cycle, with ph=0 and slot=0.
  - WARMUP: clocks run, sample_valid suppressed, frame boundaries counted.
    - On the WARMUP_FRAMES-th boundary: go to RUN.
    - If enable=0 first: go to STOP.
  - RUN: capture/emit as above. enable=0 -> STOP.
  - STOP: clocks keep running until the next frame boundary, then go to IDLE. bclk=0 and lrclk=0 from that cycle. sample_valid is suppressed. enable is ignored in STOP.
  - IDLE re-entry: from IDLE with enable=1, enter WARMUP again with a full warm-up, because the mic powers down when bclk stops.
- sel_cfg changes while not IDLE are ignored until the next IDLE->WARMUP transition.
- If enable and the frame boundary coincide in WARMUP on the last warm-up frame, enable=0 wins and the FSM goes to STOP.

Test Plan:
- Reset: hold arstn low 5 cycles with enable=1 -> all outputs 0, state=0, bclk static.
- Timing (WARMUP_FRAMES=2, defaults):
  - Raise enable -> state=1 next cycle.
  - bclk period 4 cycles at 50% duty.
  - lrclk low 128 cycles then high 128 cycles.
  - state=2 after 512 cycles.
  - No sample_valid during those 512 cycles.
- Left capture (sel_cfg=0): the mic model drives 24'hA5C3F1 MSB-first at left slots 1..24 -> sample_valid pulses once per 256 cycles, sample_data=24'hA5C3F1, one cycle after the slot-24 sample point, and sel=0.
- Right capture (sel_cfg=1): left carries 24'h111111, right carries 24'h800001 -> sample_data=24'h800001, sel=1, and left data is never emitted.
- Stop mid-frame: drop enable at slot 10 in RUN -> state=3, no sample_valid, clocks run through slot 63. state=0 at the boundary, then bclk=0 and lrclk=0 stay constant.
- Reset mid-RUN: pulse arstn low at slot 20 -> immediate reset values. After release with enable=1, WARMUP repeats the full 2 frames before the first sample_valid.
